// File: rtl/run_control.sv
// Run/step sequencer: turns front-panel controls into the datapath clock-enable.
// Define RUN_CONTROL_BREAKPOINT_EN to build the PC breakpoint comparator.
module run_control #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_W          = 16
) (
    input  logic              i_oszClk,
    input  logic              i_nReset,
    input  logic              i_btnStep,
    input  logic              i_swInstrNCycle,
    input  logic              i_swStepNRun,
    input  logic              i_swEnableBreakpoint,
    input  logic [ADDR_W-1:0] i_breakpointAddress,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_instrDone,
    output logic              o_cpuClkEn,
    output logic              o_halted,
    output logic              o_breakpointHit,
    output logic [1:0]        o_state,
    output logic [15:0]       o_instrCount
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_HALT       = 2'b00;
    localparam logic [1:0] S_RUN        = 2'b01;
    localparam logic [1:0] S_STEP_CYCLE = 2'b10;
    localparam logic [1:0] S_STEP_INSTR = 2'b11;

    logic [1:0]       btnSync_q, instrSync_q, stepSync_q, bpSync_q;
    logic [CNT_W-1:0] dbCnt_q;
    logic             btnDb_q, btnDbDly_q;
    logic [1:0]       state_q, state_d;
    logic             hit_q, hit_d;
    logic [15:0]      instrCnt_q;
    logic             stepReq, bpMatch;

    always_ff @(posedge i_oszClk or negedge i_nReset) begin
        if (!i_nReset) begin
            btnSync_q   <= '0;
            instrSync_q <= '0;
            stepSync_q  <= '0;
            bpSync_q    <= '0;
        end else begin
            btnSync_q   <= {btnSync_q[0], i_btnStep};
            instrSync_q <= {instrSync_q[0], i_swInstrNCycle};
            stepSync_q  <= {stepSync_q[0], i_swStepNRun};
            bpSync_q    <= {bpSync_q[0], i_swEnableBreakpoint};
        end
    end

    // Counter restarts whenever the synced level falls back to the accepted one.
    always_ff @(posedge i_oszClk or negedge i_nReset) begin
        if (!i_nReset) begin
            dbCnt_q    <= '0;
            btnDb_q    <= 1'b0;
            btnDbDly_q <= 1'b0;
        end else begin
            btnDbDly_q <= btnDb_q;
            if (btnSync_q[1] == btnDb_q) begin
                dbCnt_q <= '0;
            end else if (dbCnt_q == CNT_LAST) begin
                dbCnt_q <= '0;
                btnDb_q <= btnSync_q[1];
            end else begin
                dbCnt_q <= dbCnt_q + 1'b1;
            end
        end
    end

    assign stepReq    = btnDb_q & ~btnDbDly_q;
    assign o_cpuClkEn = (state_q != S_HALT);
    assign o_halted   = (state_q == S_HALT);
    assign o_state    = state_q;

`ifdef RUN_CONTROL_BREAKPOINT_EN
    assign bpMatch = bpSync_q[1] & i_instrDone & o_cpuClkEn
                   & (i_pc == i_breakpointAddress);

    always_ff @(posedge i_oszClk or negedge i_nReset) begin
        if (!i_nReset) hit_q <= 1'b0;
        else           hit_q <= hit_d;
    end
`else
    logic unused_bp;
    assign unused_bp = &{1'b0, bpSync_q, i_breakpointAddress, i_pc, hit_d};
    assign bpMatch   = 1'b0;
    assign hit_q     = 1'b0;
`endif

    assign o_breakpointHit = hit_q;

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        case (state_q)
            S_HALT: begin
                if (stepSync_q[1]) begin
                    if (stepReq) begin
                        state_d = instrSync_q[1] ? S_STEP_INSTR : S_STEP_CYCLE;
                        hit_d   = 1'b0;
                    end
                end else if (!hit_q) begin
                    state_d = S_RUN;
                end else if (stepReq) begin
                    state_d = S_RUN;
                    hit_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (bpMatch) begin
                    state_d = S_HALT;
                    hit_d   = 1'b1;
                end else if (stepSync_q[1]) begin
                    state_d = S_HALT;
                end
            end
            S_STEP_CYCLE: state_d = S_HALT;
            S_STEP_INSTR: begin
                if (bpMatch)     hit_d   = 1'b1;
                if (i_instrDone) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge i_oszClk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q    <= S_HALT;
            instrCnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (o_cpuClkEn && i_instrDone) instrCnt_q <= instrCnt_q + 16'd1;
        end
    end

    assign o_instrCount = instrCnt_q;

endmodule

// File: doc/run_control.md
# run_control

Run/step sequencer for the EDiC datapath. Turns the front-panel controls (step button, instruction/cycle switch, step/run switch, breakpoint enable and address) into a clock-enable for the CPU datapath. It supports free-running execution, single-cycle stepping, single-instruction stepping and halting on a PC breakpoint. It sits between the board I/O and the datapath's clock-enable input, and also keeps a retired-instruction counter for the seven-segment display.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a step-button level is accepted (10 ms at 5 MHz).
- ADDR_W, 16, width of PC and breakpoint address.
- i_oszClk  in  1  system clock (5 MHz oscillator); one clock domain.
- i_nReset  in  1  asynchronous, active-low reset.
- i_btnStep  in  1  raw step button, asynchronous, bouncy; 1 = pressed.
- i_swInstrNCycle  in  1  step granularity; 1 = instruction, 0 = cycle. Asynchronous.
- i_swStepNRun  in  1  mode; 1 = step, 0 = run. Asynchronous.
- i_swEnableBreakpoint  in  1  breakpoint enable. Asynchronous.
- i_breakpointAddress  in  ADDR_W  breakpoint PC; quasi-static.
- i_pc  in  ADDR_W  datapath PC; in a cycle with i_instrDone=1 it holds the address of the next instruction.
- i_instrDone  in  1  high during the last microcycle of an instruction.
- o_cpuClkEn  out  1  datapath clock-enable; the datapath advances one microcycle per enabled cycle.
- o_halted  out  1  1 in HALT.
- o_breakpointHit  out  1  sticky; set on breakpoint halt.
- o_state  out  2  00 HALT, 01 RUN, 10 STEP_CYCLE, 11 STEP_INSTR.
- o_instrCount  out  16  instructions retired, for display.

## Operation
- **Input conditioning**
  - All switches and the button pass through 2-FF synchronizers.
  - The button is also debounced: a counter reloads on every change of the synced level. The debounced level updates only after DEBOUNCE_CYCLES stable cycles.
  - stepReq is a one-cycle pulse on a debounced 0→1 edge.
- **Enable decode:** o_cpuClkEn = (state != HALT), decoded directly from the state register. An "executed cycle" is any cycle with o_cpuClkEn=1.
- **Breakpoint match (bpMatch):** i_swEnableBreakpoint & i_instrDone & o_cpuClkEn & (i_pc == i_breakpointAddress).
- **HALT**
  - run switch, o_breakpointHit=0 → RUN.
  - run switch, o_breakpointHit=1: stepReq → clear hit, go to RUN.
  - step switch: stepReq → STEP_CYCLE (cycle mode) or STEP_INSTR (instruction mode). Also clears o_breakpointHit.
- **RUN**
  - Step switch → HALT.
  - bpMatch → HALT and set o_breakpointHit; the matching cycle still executes.
  - stepReq is ignored.
- **STEP_CYCLE:** exactly one executed cycle, then HALT unconditionally.
- **STEP_INSTR**
  - Executes until the executed cycle with i_instrDone=1, then HALT.
  - A mode-switch change mid-instruction has no effect; the instruction completes.
  - bpMatch sets o_breakpointHit in this state too.
- **Instruction counter:** o_instrCount increments on each executed cycle with i_instrDone=1 and wraps from 0xFFFF to 0.
- **Reset:** asynchronous. State goes to HALT, counters and synchronizers clear, o_breakpointHit=0, o_instrCount=0, o_cpuClkEn=0, o_halted=1, o_state=00. Reset mid-instruction abandons the instruction immediately.

## Timing
- Button press to stepReq: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- stepReq in cycle t → state changes at edge ending t → o_cpuClkEn=1 in cycle t+1.
- Run-switch change to RUN/HALT transition: 2 sync cycles + 1.
- bpMatch or step completion in cycle t → o_cpuClkEn=0 from cycle t+1. No extra cycle executes.
- o_cpuClkEn, o_halted, o_state and o_breakpointHit change only on clock edges or on reset; they are glitch-free.

## Configuration
- **RUN_CONTROL_BREAKPOINT_EN defined:** breakpoint comparator and o_breakpointHit behave as above.
- **Not defined:**
  - Comparator and sticky bit are removed; o_breakpointHit is tied to 0.
  - i_swEnableBreakpoint and i_breakpointAddress are ignored.
  - RUN leaves only via the step switch.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and a datapath model with 4-microcycle instructions and PC incrementing by 1.
- **Reset:** drop i_nReset mid-RUN → same cycle o_cpuClkEn=0, o_state=00, o_instrCount=0.
- **Cycle step:**
  - Stimulus: step switch, cycle mode, one press held 10 cycles.
  - Required: exactly 1 enabled cycle, o_instrCount unchanged.
  - Bounce check: a 2-cycle glitch press produces 0 enabled cycles.
- **Instruction step:**
  - Stimulus: instruction mode, 3 presses.
  - Required: exactly 12 enabled cycles, o_instrCount=3, o_halted=1 after each press.
- **Breakpoint:**
  - Stimulus: breakpoint 0x00FF, enabled, run mode from PC 0.
  - Required: halt after the instruction with i_pc=0x00FF at i_instrDone, o_breakpointHit=1, o_instrCount=0x00FF.
  - A following press resumes RUN with o_breakpointHit=0.
- **Run/step toggle:** flip to step mid-instruction → HALT within 3 cycles. Flipping back → RUN resumes at the same microcycle.
- **Counter wrap:** preload via 0xFFFF instructions → next retirement gives o_instrCount=0x0000.
